// File: rtl/hpc_regbank.sv
// Avalon-MM register bank: version, command, error counter, RW control words
// and read-only snapshots of live status channels.
module hpc_regbank #(
   parameter int WIDTH       = 32,
   parameter int ADDR_W      = 6,
   parameter int N_CTRL      = 4,
   parameter int N_STAT      = 8,
   parameter int SYS_VERSION = 21
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [ADDR_W-1:0]        slave_address,
   input  logic                     slave_read,
   input  logic                     slave_write,
   input  logic [WIDTH-1:0]         slave_writedata,
   output logic [WIDTH-1:0]         slave_readdata,
   output logic                     slave_readdatavalid,
   output logic [N_CTRL*WIDTH-1:0]  ctrl_out,
   input  logic [N_STAT*WIDTH-1:0]  stat_in,
   output logic                     snap_pulse
);

   localparam int IDX_W     = ADDR_W - 2;
   localparam int CTRL_BASE = 4;
   localparam int STAT_BASE = CTRL_BASE + N_CTRL;
   localparam int N_MAP     = STAT_BASE + N_STAT;
   localparam logic [WIDTH-1:0] VERSION_VAL = WIDTH'(SYS_VERSION);
   localparam logic [WIDTH-1:0] ERR_MAX     = '1;

   if (N_MAP > (1 << IDX_W)) begin : g_map_check
      $error("hpc_regbank: register map does not fit in the address space");
   end

   logic [N_CTRL*WIDTH-1:0] ctrl_q;
   logic [N_STAT*WIDTH-1:0] stat_q;
   logic [WIDTH-1:0]        err_cnt;

   int               idx;
   logic             rd_ok;
   logic             wr_ok;
   logic             collide;
   logic             mapped;
   logic             ro_idx;
   logic             err_evt;
   logic             do_snap;
   logic             do_clr;
   logic [WIDTH-1:0] rd_mux;
   logic             unused_addr;

   assign unused_addr = ^slave_address[1:0];
   assign ctrl_out    = ctrl_q;

   always_comb begin
      idx     = int'(slave_address[ADDR_W-1:2]);
      rd_ok   = slave_read & ~slave_write;
      wr_ok   = slave_write & ~slave_read;
      collide = slave_read & slave_write;
      mapped  = (idx < N_MAP);
      ro_idx  = (idx == 0) || (idx == 2) || (idx == 3) || ((idx >= STAT_BASE) && mapped);
      err_evt = collide || ((rd_ok || wr_ok) && !mapped) || (wr_ok && mapped && ro_idx);
      do_snap = wr_ok && (idx == 1) && slave_writedata[0];
      do_clr  = wr_ok && (idx == 1) && slave_writedata[1];

      // CMD, idx 3 and unmapped indices fall through to zero
      rd_mux = '0;
      if (idx == 0) rd_mux = VERSION_VAL;
      if (idx == 2) rd_mux = err_cnt;
      for (int k = 0; k < N_CTRL; k++)
         if (idx == CTRL_BASE + k) rd_mux = ctrl_q[k*WIDTH +: WIDTH];
      for (int s = 0; s < N_STAT; s++)
         if (idx == STAT_BASE + s) rd_mux = stat_q[s*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q              <= '0;
         stat_q              <= '0;
         err_cnt             <= '0;
         slave_readdata      <= '0;
         slave_readdatavalid <= 1'b0;
         snap_pulse          <= 1'b0;
      end else begin
         slave_readdatavalid <= rd_ok;
         if (rd_ok) slave_readdata <= rd_mux;

         snap_pulse <= do_snap;
         if (do_snap) stat_q <= stat_in;

         for (int k = 0; k < N_CTRL; k++)
            if (wr_ok && (idx == CTRL_BASE + k)) ctrl_q[k*WIDTH +: WIDTH] <= slave_writedata;

         // a clear always beats a same-cycle error event
         if (do_clr)
            err_cnt <= '0;
         else if (err_evt && (err_cnt != ERR_MAX))
            err_cnt <= err_cnt + WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_hpc_regbank.sv
// Directed bench for hpc_regbank: a 32-bit instance with a wide address space
// and a 4-bit instance for counter saturation.
module tb_hpc_regbank;

   logic         clk;
   logic         reset_n;
   logic [7:0]   address;
   logic         read;
   logic         write;
   logic [31:0]  wdata;
   logic [31:0]  rdata;
   logic         valid;
   logic [127:0] ctrl;
   logic [255:0] stat;
   logic         snap;

   logic [5:0]   n_address;
   logic         n_read;
   logic         n_write;
   logic [3:0]   n_wdata;
   logic [3:0]   n_rdata;
   logic         n_valid;
   logic [15:0]  n_ctrl;
   logic [31:0]  n_stat;
   logic         n_snap;

   int total = 0;
   int bad   = 0;

   hpc_regbank #(.WIDTH(32), .ADDR_W(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .slave_address(address), .slave_read(read), .slave_write(write),
      .slave_writedata(wdata), .slave_readdata(rdata),
      .slave_readdatavalid(valid), .ctrl_out(ctrl), .stat_in(stat),
      .snap_pulse(snap)
   );

   hpc_regbank #(.WIDTH(4)) dut_n (
      .clk(clk), .reset_n(reset_n),
      .slave_address(n_address), .slave_read(n_read), .slave_write(n_write),
      .slave_writedata(n_wdata), .slave_readdata(n_rdata),
      .slave_readdatavalid(n_valid), .ctrl_out(n_ctrl), .stat_in(n_stat),
      .snap_pulse(n_snap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one bus cycle starting at a falling edge; returns at the next falling edge
   task automatic drive(input logic rd, input logic wr, input int idx, input logic [31:0] d);
      read    = rd;
      write   = wr;
      address = 8'(idx * 4);
      wdata   = d;
      @(negedge clk);
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic test_reset;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      total++; if (snap !== 1'b0) begin bad++; $display("FAIL reset_snap got=%b exp=0", snap); end
      total++; if (ctrl !== 128'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", ctrl); end
   endtask

   task automatic test_version;
      drive(1'b1, 1'b0, 0, 32'h0);
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL version_valid got=%b exp=1", valid); end
      total++; if (rdata !== 32'd21) begin bad++; $display("FAIL version_data got=%h exp=%h", rdata, 32'd21); end
      @(negedge clk);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL version_valid_drop got=%b exp=0", valid); end
      total++; if (rdata !== 32'd21) begin bad++; $display("FAIL version_hold got=%h exp=%h", rdata, 32'd21); end
   endtask

   task automatic test_ctrl;
      drive(1'b0, 1'b1, 5, 32'hDEADBEEF);
      total++; if (ctrl[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL ctrl1_out got=%h exp=deadbeef", ctrl[63:32]); end
      total++; if ({ctrl[127:64], ctrl[31:0]} !== 96'h0) begin bad++; $display("FAIL ctrl_others got=%h exp=0", {ctrl[127:64], ctrl[31:0]}); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL ctrl_write_valid got=%b exp=0", valid); end
      drive(1'b1, 1'b0, 5, 32'h0);
      total++; if (rdata !== 32'hDEADBEEF || valid !== 1'b1) begin bad++; $display("FAIL ctrl1_read got=%h/%b exp=deadbeef/1", rdata, valid); end
   endtask

   task automatic test_back_to_back;
      read = 1'b1; write = 1'b0;
      address = 8'(3 * 4);
      @(negedge clk);
      total++; if (valid !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL b2b_idx3 got=%h/%b exp=0/1", rdata, valid); end
      address = 8'(5 * 4);
      @(negedge clk);
      total++; if (valid !== 1'b1 || rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_idx5 got=%h/%b exp=deadbeef/1", rdata, valid); end
      address = 8'(1 * 4);
      @(negedge clk);
      total++; if (valid !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL b2b_cmd got=%h/%b exp=0/1", rdata, valid); end
      address = 8'(0);
      @(negedge clk);
      total++; if (valid !== 1'b1 || rdata !== 32'd21) begin bad++; $display("FAIL b2b_idx0 got=%h/%b exp=15/1", rdata, valid); end
      read = 1'b0;
      @(negedge clk);
      total++; if (valid !== 1'b0 || rdata !== 32'd21) begin bad++; $display("FAIL b2b_idle got=%h/%b exp=15/0", rdata, valid); end
   endtask

   task automatic test_snap;
      stat[31:0]  = 32'h11;
      stat[63:32] = 32'hA5;
      drive(1'b0, 1'b1, 1, 32'h1);
      total++; if (snap !== 1'b1) begin bad++; $display("FAIL snap_pulse_high got=%b exp=1", snap); end
      stat[31:0]  = 32'h22;
      stat[63:32] = 32'h5A;
      drive(1'b1, 1'b0, 8, 32'h0);
      total++; if (snap !== 1'b0) begin bad++; $display("FAIL snap_pulse_low got=%b exp=0", snap); end
      total++; if (rdata !== 32'h11 || valid !== 1'b1) begin bad++; $display("FAIL snap_stat0 got=%h/%b exp=11/1", rdata, valid); end
      drive(1'b1, 1'b0, 9, 32'h0);
      total++; if (rdata !== 32'hA5) begin bad++; $display("FAIL snap_stat1 got=%h exp=a5", rdata); end
   endtask

   task automatic test_err;
      drive(1'b0, 1'b1, 0, 32'h99);
      drive(1'b1, 1'b0, 63, 32'h0);
      total++; if (valid !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL err_unmapped_read got=%h/%b exp=0/1", rdata, valid); end
      drive(1'b1, 1'b1, 4, 32'hFFFFFFFF);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL err_collide_valid got=%b exp=0", valid); end
      total++; if (ctrl[31:0] !== 32'h0) begin bad++; $display("FAIL err_collide_ctrl got=%h exp=0", ctrl[31:0]); end
      drive(1'b1, 1'b0, 2, 32'h0);
      total++; if (rdata !== 32'd3) begin bad++; $display("FAIL err_count3 got=%0d exp=3", rdata); end
      drive(1'b1, 1'b0, 0, 32'h0);
      total++; if (rdata !== 32'd21) begin bad++; $display("FAIL err_version_kept got=%h exp=15", rdata); end
      drive(1'b0, 1'b1, 1, 32'h2);
      total++; if (snap !== 1'b0) begin bad++; $display("FAIL err_clr_nosnap got=%b exp=0", snap); end
      drive(1'b1, 1'b0, 2, 32'h0);
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL err_cleared got=%0d exp=0", rdata); end
      drive(1'b0, 1'b1, 8, 32'h77);
      drive(1'b1, 1'b0, 2, 32'h0);
      total++; if (rdata !== 32'd1) begin bad++; $display("FAIL err_stat_write got=%0d exp=1", rdata); end
      stat[31:0] = 32'h44;
      drive(1'b0, 1'b1, 1, 32'h3);
      total++; if (snap !== 1'b1) begin bad++; $display("FAIL err_both_snap got=%b exp=1", snap); end
      drive(1'b1, 1'b0, 2, 32'h0);
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL err_both_clear got=%0d exp=0", rdata); end
      drive(1'b1, 1'b0, 8, 32'h0);
      total++; if (rdata !== 32'h44) begin bad++; $display("FAIL err_both_stat got=%h exp=44", rdata); end
   endtask

   task automatic test_reset_abort;
      drive(1'b0, 1'b1, 4, 32'h5);
      total++; if (ctrl[31:0] !== 32'h5) begin bad++; $display("FAIL abort_ctrl0_set got=%h exp=5", ctrl[31:0]); end
      read = 1'b1; address = 8'h0;
      #2 reset_n = 1'b0;
      #1;
      total++; if (ctrl !== 128'h0) begin bad++; $display("FAIL abort_ctrl_async got=%h exp=0", ctrl); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL abort_rdata_async got=%h exp=0", rdata); end
      @(negedge clk);
      read = 1'b0;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL abort_no_valid got=%b exp=0", valid); end
      reset_n = 1'b1;
      drive(1'b1, 1'b0, 0, 32'h0);
      total++; if (valid !== 1'b1 || rdata !== 32'd21) begin bad++; $display("FAIL abort_first_read got=%h/%b exp=15/1", rdata, valid); end
      drive(1'b1, 1'b0, 5, 32'h0);
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL abort_ctrl1_cleared got=%h exp=0", rdata); end
   endtask

   task automatic n_read_err(output logic [3:0] v);
      n_read = 1'b1; n_address = 6'(2 * 4);
      @(negedge clk);
      n_read = 1'b0;
      v = n_rdata;
   endtask

   task automatic test_saturate;
      logic [3:0] v;
      for (int i = 0; i < 14; i++) begin
         n_write = 1'b1; n_address = 6'h0; n_wdata = 4'h3;
         @(negedge clk);
      end
      n_write = 1'b0;
      n_read_err(v);
      total++; if (v !== 4'hE) begin bad++; $display("FAIL sat_count14 got=%h exp=e", v); end
      for (int i = 0; i < 2; i++) begin
         n_write = 1'b1; n_address = 6'h0;
         @(negedge clk);
      end
      n_write = 1'b0;
      n_read_err(v);
      total++; if (v !== 4'hF) begin bad++; $display("FAIL sat_count16 got=%h exp=f", v); end
      for (int i = 0; i < 3; i++) begin
         n_write = 1'b1; n_address = 6'h0;
         @(negedge clk);
      end
      n_write = 1'b0;
      n_read_err(v);
      total++; if (v !== 4'hF) begin bad++; $display("FAIL sat_count19 got=%h exp=f", v); end
   endtask

   initial begin
      reset_n = 1'b0;
      address = '0; read = 1'b0; write = 1'b0; wdata = '0; stat = '0;
      n_address = '0; n_read = 1'b0; n_write = 1'b0; n_wdata = '0; n_stat = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      test_reset;
      test_version;
      test_ctrl;
      test_back_to_back;
      test_snap;
      test_err;
      test_reset_abort;
      test_saturate;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
